// File: rtl/pulse_gen_pkg.sv
// Shared types for the multi-channel pulse/PWM generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ONE  = 2'd2
    } pg_state_t;

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse/PWM channel: state machine, period counter and config latches.
//
// state  | meaning
// S_IDLE | channel disabled or waiting for a one-shot start; out low
// S_RUN  | continuous mode, restarts every period
// S_ONE  | one-shot mode, returns to S_IDLE after a single period
module pulse_gen_channel
    import pulse_gen_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         tick,
    input  logic         ch_ena,
    input  logic         oneshot,
    input  logic         start,
    input  logic [N-1:0] period,
    input  logic [N-1:0] width,
    output logic         out,
    output logic         wrap,
    output logic         busy
);

    pg_state_t    state, state_nxt;
    logic [N-1:0] cnt, cnt_nxt;
    logic [N-1:0] per_l, per_nxt;
    logic [N-1:0] wid_l, wid_nxt;
    logic [N-1:0] cnt_inc;
    logic         out_nxt;
    logic         wrap_nxt;

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        per_nxt   = per_l;
        wid_nxt   = wid_l;
        out_nxt   = out;
        wrap_nxt  = 1'b0;

        if (!ch_ena) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            out_nxt   = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ena && (!oneshot || start)) begin
                        state_nxt = oneshot ? S_ONE : S_RUN;
                        cnt_nxt   = '0;
                        per_nxt   = period;
                        wid_nxt   = width;
                        out_nxt   = (width != '0);
                    end
                end
                S_RUN, S_ONE: begin
                    if (tick) begin
                        if (cnt == per_l) begin
                            wrap_nxt = 1'b1;
                            cnt_nxt  = '0;
                            if (state == S_ONE) begin
                                out_nxt   = 1'b0;
                                state_nxt = S_IDLE;
                            end else begin
                                // new config is only picked up here, so no runt pulses
                                per_nxt = period;
                                wid_nxt = width;
                                out_nxt = (width != '0);
                            end
                        end else begin
                            cnt_nxt = cnt_inc;
                            out_nxt = (cnt_inc < wid_l);
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            per_l <= '0;
            wid_l <= '0;
            out   <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            per_l <= per_nxt;
            wid_l <= wid_nxt;
            out   <= out_nxt;
            wrap  <= wrap_nxt;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: rtl/pulse_generator_mc.sv
// Multi-channel programmable pulse/PWM generator with a shared tick.
// Optional shared prescaler enabled by defining PULSE_GEN_PRESCALE_EN.
module pulse_generator_mc
    import pulse_gen_pkg::*;
#(
    parameter int N        = 8,
    parameter int CHANNELS = 2,
    parameter int PW       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
`ifdef PULSE_GEN_PRESCALE_EN
    input  logic [PW-1:0]         prescale,
`endif
    input  logic [CHANNELS-1:0]   ch_ena,
    input  logic [CHANNELS-1:0]   oneshot,
    input  logic [CHANNELS-1:0]   start,
    input  logic [CHANNELS*N-1:0] period,
    input  logic [CHANNELS*N-1:0] width,
    output logic [CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]   wrap,
    output logic [CHANNELS-1:0]   busy
);

    logic tick;

    if (PW < 1) begin : g_pw_check
        $error("pulse_generator_mc: PW must be at least 1");
    end

`ifdef PULSE_GEN_PRESCALE_EN
    logic [PW-1:0] pcnt;

    assign tick = ena && (pcnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (ena) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end
`else
    assign tick = ena;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pulse_gen_channel #(.N(N)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena),
            .tick    (tick),
            .ch_ena  (ch_ena[c]),
            .oneshot (oneshot[c]),
            .start   (start[c]),
            .period  (period[c*N +: N]),
            .width   (width[c*N +: N]),
            .out     (out[c]),
            .wrap    (wrap[c]),
            .busy    (busy[c])
        );
    end

endmodule
